// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types and round constants for the ASCON-128 controller
package ascon_pkg;

    localparam int ROUNDS_A      = 12;
    localparam int ROUND_START_B = 6;

    localparam logic [3:0] ROUND_FIRST_A = 4'd0;
    localparam logic [3:0] ROUND_FIRST_B = 4'(ROUND_START_B);
    localparam logic [3:0] ROUND_LAST    = 4'(ROUNDS_A - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        AD,
        PT,
        FINAL,
        DONE
    } t_ctrl_state;

endpackage

// File: rtl/ascon_round_counter.sv
// rtl/ascon_round_counter.sv - 4-bit round index with p12/p6 start load, stall and terminal flag
module ascon_round_counter
    import ascon_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       load,
    input  logic       load_b,
    input  logic       advance,
    output logic [3:0] round,
    output logic       last
);

    assign last = (round == ROUND_LAST);

    // Saturates at the last round so the index can never leave 0..11.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            round <= ROUND_FIRST_A;
        end else if (clear) begin
            round <= ROUND_FIRST_A;
        end else if (load) begin
            round <= load_b ? ROUND_FIRST_B : ROUND_FIRST_A;
        end else if (advance && !last) begin
            round <= round + 4'd1;
        end
    end

endmodule

// File: rtl/ascon_controller.sv
// rtl/ascon_controller.sv - sequencing FSM driving the one-round-per-cycle ASCON-128 permutation
module ascon_controller
    import ascon_pkg::*;
#(
    parameter int BLOCK_CNT_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       i_enable,
    input  logic                       i_start,
    input  logic [BLOCK_CNT_WIDTH-1:0] i_num_ad_blocks,
    input  logic [BLOCK_CNT_WIDTH-1:0] i_num_pt_blocks,
    input  logic                       i_data_valid,
    output logic                       o_data_ready,
    output logic                       o_sys_enable,
    output logic                       o_mux_select,
    output logic                       o_enable_xor_key_begin,
    output logic                       o_enable_xor_data_begin,
    output logic                       o_enable_xor_key_end,
    output logic                       o_enable_xor_lsb_end,
    output logic                       o_enable_state_reg,
    output logic                       o_enable_cipher_reg,
    output logic                       o_enable_tag_reg,
    output logic [3:0]                 o_round,
    output logic                       o_busy,
    output logic                       o_cipher_valid,
    output logic                       o_done
);

    localparam logic [BLOCK_CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [BLOCK_CNT_WIDTH-1:0] CNT_ONE  = BLOCK_CNT_WIDTH'(1);
    localparam logic [BLOCK_CNT_WIDTH-1:0] CNT_TWO  = BLOCK_CNT_WIDTH'(2);

    t_ctrl_state state, state_next;
    logic [BLOCK_CNT_WIDTH-1:0] ad_cnt, ad_next, pt_cnt, pt_next;
    logic [3:0] rc;
    logic       rc_last, rc_clear, rc_load, rc_load_b, rc_advance;
    logic       cipher_pulse;

    ascon_round_counter u_round_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (rc_clear),
        .load    (rc_load),
        .load_b  (rc_load_b),
        .advance (rc_advance),
        .round   (rc),
        .last    (rc_last)
    );

    // Reset gates the pass-through so every output reads 0 while reset_n is low.
    assign o_sys_enable   = i_enable & reset_n;
    assign o_busy         = (state != IDLE);
    assign o_cipher_valid = cipher_pulse;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ad_cnt       <= CNT_ZERO;
            pt_cnt       <= CNT_ZERO;
            cipher_pulse <= 1'b0;
        end else begin
            state        <= state_next;
            ad_cnt       <= ad_next;
            pt_cnt       <= pt_next;
            cipher_pulse <= o_enable_cipher_reg;
        end
    end

    always_comb begin
        state_next              = state;
        ad_next                 = ad_cnt;
        pt_next                 = pt_cnt;
        rc_clear                = 1'b0;
        rc_load                 = 1'b0;
        rc_load_b               = 1'b0;
        rc_advance              = 1'b0;
        o_data_ready            = 1'b0;
        o_mux_select            = 1'b0;
        o_enable_xor_key_begin  = 1'b0;
        o_enable_xor_data_begin = 1'b0;
        o_enable_xor_key_end    = 1'b0;
        o_enable_xor_lsb_end    = 1'b0;
        o_enable_state_reg      = 1'b0;
        o_enable_cipher_reg     = 1'b0;
        o_enable_tag_reg        = 1'b0;
        o_round                 = rc;
        o_done                  = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = INIT;
                    ad_next    = i_num_ad_blocks;
                    pt_next    = (i_num_pt_blocks == CNT_ZERO) ? CNT_ONE : i_num_pt_blocks;
                    rc_load    = 1'b1;
                end
            end
            INIT: begin
                o_enable_state_reg = 1'b1;
                o_mux_select       = (rc != ROUND_FIRST_A);
                rc_advance         = 1'b1;
                if (rc_last) begin
                    o_enable_xor_key_end = 1'b1;
                    rc_load              = 1'b1;
                    if (ad_cnt == CNT_ZERO) begin
                        o_enable_xor_lsb_end = 1'b1;
                        state_next           = (pt_cnt > CNT_ONE) ? PT : FINAL;
                        rc_load_b            = (pt_cnt > CNT_ONE);
                    end else begin
                        state_next = AD;
                        rc_load_b  = 1'b1;
                    end
                end
            end
            AD, PT: begin
                o_mux_select = 1'b1;
                if (rc == ROUND_FIRST_B) begin
                    // Round counter holds at 6 until a block is accepted.
                    o_data_ready = 1'b1;
                    if (i_data_valid) begin
                        o_enable_state_reg      = 1'b1;
                        o_enable_xor_data_begin = 1'b1;
                        o_enable_cipher_reg     = (state == PT);
                        rc_advance              = 1'b1;
                    end
                end else begin
                    o_enable_state_reg = 1'b1;
                    rc_advance         = 1'b1;
                    if (rc_last) begin
                        rc_load = 1'b1;
                        if (state == AD) begin
                            ad_next = ad_cnt - CNT_ONE;
                            if (ad_cnt == CNT_ONE) begin
                                o_enable_xor_lsb_end = 1'b1;
                                state_next           = (pt_cnt > CNT_ONE) ? PT : FINAL;
                                rc_load_b            = (pt_cnt > CNT_ONE);
                            end else begin
                                rc_load_b = 1'b1;
                            end
                        end else begin
                            pt_next = pt_cnt - CNT_ONE;
                            if (pt_cnt == CNT_TWO) begin
                                state_next = FINAL;
                            end else begin
                                rc_load_b = 1'b1;
                            end
                        end
                    end
                end
            end
            FINAL: begin
                o_mux_select = 1'b1;
                if (rc == ROUND_FIRST_A) begin
                    o_data_ready = 1'b1;
                    if (i_data_valid) begin
                        o_enable_state_reg      = 1'b1;
                        o_enable_xor_data_begin = 1'b1;
                        o_enable_xor_key_begin  = 1'b1;
                        o_enable_cipher_reg     = 1'b1;
                        rc_advance              = 1'b1;
                    end
                end else begin
                    o_enable_state_reg = 1'b1;
                    rc_advance         = 1'b1;
                    if (rc_last) begin
                        o_enable_xor_key_end = 1'b1;
                        o_enable_tag_reg     = 1'b1;
                        state_next           = DONE;
                        rc_clear             = 1'b1;
                    end
                end
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                rc_clear   = 1'b1;
            end
        endcase

        // Dropping the system enable soft-resets the controller from any state.
        if (!i_enable) begin
            state_next              = IDLE;
            ad_next                 = CNT_ZERO;
            pt_next                 = CNT_ZERO;
            rc_clear                = 1'b1;
            rc_load                 = 1'b0;
            rc_advance              = 1'b0;
            o_data_ready            = 1'b0;
            o_mux_select            = 1'b0;
            o_enable_xor_key_begin  = 1'b0;
            o_enable_xor_data_begin = 1'b0;
            o_enable_xor_key_end    = 1'b0;
            o_enable_xor_lsb_end    = 1'b0;
            o_enable_state_reg      = 1'b0;
            o_enable_cipher_reg     = 1'b0;
            o_enable_tag_reg        = 1'b0;
            o_round                 = 4'd0;
            o_done                  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ascon_controller.sv
// tb/tb_ascon_controller.sv - directed self-checking bench for ascon_controller
module tb_ascon_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       i_enable;
    logic       i_start;
    logic [7:0] i_num_ad_blocks;
    logic [7:0] i_num_pt_blocks;
    logic       i_data_valid;
    logic       o_data_ready, o_sys_enable, o_mux_select;
    logic       o_enable_xor_key_begin, o_enable_xor_data_begin;
    logic       o_enable_xor_key_end, o_enable_xor_lsb_end;
    logic       o_enable_state_reg, o_enable_cipher_reg, o_enable_tag_reg;
    logic [3:0] o_round;
    logic       o_busy, o_cipher_valid, o_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ascon_controller #(.BLOCK_CNT_WIDTH(8)) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .i_enable                (i_enable),
        .i_start                 (i_start),
        .i_num_ad_blocks         (i_num_ad_blocks),
        .i_num_pt_blocks         (i_num_pt_blocks),
        .i_data_valid            (i_data_valid),
        .o_data_ready            (o_data_ready),
        .o_sys_enable            (o_sys_enable),
        .o_mux_select            (o_mux_select),
        .o_enable_xor_key_begin  (o_enable_xor_key_begin),
        .o_enable_xor_data_begin (o_enable_xor_data_begin),
        .o_enable_xor_key_end    (o_enable_xor_key_end),
        .o_enable_xor_lsb_end    (o_enable_xor_lsb_end),
        .o_enable_state_reg      (o_enable_state_reg),
        .o_enable_cipher_reg     (o_enable_cipher_reg),
        .o_enable_tag_reg        (o_enable_tag_reg),
        .o_round                 (o_round),
        .o_busy                  (o_busy),
        .o_cipher_valid          (o_cipher_valid),
        .o_done                  (o_done)
    );

    task automatic check(input string tag, input longint observed, input longint expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Cycle 1 is the first cycle after the edge that samples i_start.
    task automatic run_enc(input int ad, input int pt, input int stall, input bit poke,
                           output int done_cyc, output int pulses, output int init_lsb,
                           output int ready_cycles, output int freeze_err, output int first_mux);
        int  w;
        int  prev_round;
        bit  prev_stalled;
        done_cyc = -1; pulses = 0; init_lsb = -1; ready_cycles = 0; freeze_err = 0; first_mux = -1;
        w = 0; prev_round = 0; prev_stalled = 1'b0;
        i_num_ad_blocks = 8'(ad);
        i_num_pt_blocks = 8'(pt);
        i_data_valid    = (stall == 0);
        i_start         = 1'b1;
        @(posedge clock); #1;
        i_start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (poke) i_start = (cyc >= 5 && cyc < 8);
            if (o_data_ready) begin
                if (w < stall) begin i_data_valid = 1'b0; w++; end
                else begin i_data_valid = 1'b1; w = 0; end
            end else begin
                i_data_valid = (stall == 0);
            end
            #1;
            if (cyc == 1) first_mux = int'(o_mux_select);
            if (o_data_ready) ready_cycles++;
            if (o_cipher_valid) pulses++;
            if (o_round == 4'd11 && o_enable_xor_key_end && !o_enable_tag_reg)
                init_lsb = int'(o_enable_xor_lsb_end);
            if (o_data_ready && !i_data_valid) begin
                if (o_enable_state_reg || (prev_stalled && int'(o_round) != prev_round))
                    freeze_err++;
                prev_stalled = 1'b1;
            end else begin
                prev_stalled = 1'b0;
            end
            prev_round = int'(o_round);
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clock); #1;
        end
        i_start = 1'b0;
        @(posedge clock); #1;
    endtask

    int done_cyc, pulses, init_lsb, ready_cycles, freeze_err, first_mux;

    initial begin
        reset_n = 1'b0; i_enable = 1'b1; i_start = 1'b0; i_data_valid = 1'b0;
        i_num_ad_blocks = 8'd0; i_num_pt_blocks = 8'd0;
        #1;
        check("reset_busy", o_busy, 0);
        check("reset_sys_enable", o_sys_enable, 0);
        check("reset_round", o_round, 0);
        check("reset_ready_done", {o_data_ready, o_done, o_enable_state_reg, o_cipher_valid}, 0);
        repeat (2) @(posedge clock);
        #1; reset_n = 1'b1;
        @(posedge clock); #1;

        // start while disabled is ignored
        i_enable = 1'b0; i_start = 1'b1;
        @(posedge clock); #1;
        check("disabled_start_busy", o_busy, 0);
        i_start = 1'b0; i_enable = 1'b1;
        @(posedge clock); #1;

        // T1
        run_enc(1, 1, 0, 1'b0, done_cyc, pulses, init_lsb, ready_cycles, freeze_err, first_mux);
        check("t1_done_cycle", done_cyc, 31);
        check("t1_cipher_pulses", pulses, 1);
        check("t1_init_lsb", init_lsb, 0);
        check("t1_first_mux", first_mux, 0);
        check("t1_ready_cycles", ready_cycles, 2);
        check("t1_idle_after", o_busy, 0);

        // T2
        run_enc(0, 3, 0, 1'b0, done_cyc, pulses, init_lsb, ready_cycles, freeze_err, first_mux);
        check("t2_done_cycle", done_cyc, 37);
        check("t2_cipher_pulses", pulses, 3);
        check("t2_init_lsb", init_lsb, 1);

        // T3
        run_enc(2, 2, 5, 1'b0, done_cyc, pulses, init_lsb, ready_cycles, freeze_err, first_mux);
        check("t3_done_cycle", done_cyc, 63);
        check("t3_cipher_pulses", pulses, 2);
        check("t3_ready_cycles", ready_cycles, 24);
        check("t3_freeze_err", freeze_err, 0);

        // T4: drop enable at AD rc=8 (cycle 15)
        i_num_ad_blocks = 8'd1; i_num_pt_blocks = 8'd1; i_data_valid = 1'b1; i_start = 1'b1;
        @(posedge clock); #1;
        i_start = 1'b0;
        repeat (14) @(posedge clock);
        #1;
        check("t4_round_before_drop", o_round, 8);
        check("t4_busy_before_drop", o_busy, 1);
        i_enable = 1'b0;
        #1;
        check("t4_sys_enable", o_sys_enable, 0);
        check("t4_state_reg_gated", o_enable_state_reg, 0);
        @(posedge clock); #1;
        check("t4_busy_after", o_busy, 0);
        check("t4_round_after", o_round, 0);
        i_enable = 1'b1;
        run_enc(1, 1, 0, 1'b0, done_cyc, pulses, init_lsb, ready_cycles, freeze_err, first_mux);
        check("t4_restart_done", done_cyc, 31);

        // T5: mid-run start ignored, then reset in FINAL
        run_enc(1, 1, 0, 1'b1, done_cyc, pulses, init_lsb, ready_cycles, freeze_err, first_mux);
        check("t5_poke_done", done_cyc, 31);
        check("t5_poke_pulses", pulses, 1);
        i_num_ad_blocks = 8'd1; i_num_pt_blocks = 8'd1; i_data_valid = 1'b1; i_start = 1'b1;
        @(posedge clock); #1;
        i_start = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        check("t5_final_round", o_round, 1);
        check("t5_final_state_reg", o_enable_state_reg, 1);
        reset_n = 1'b0;
        #1;
        check("t5_reset_busy", o_busy, 0);
        check("t5_reset_round", o_round, 0);
        check("t5_reset_outputs", {o_sys_enable, o_enable_state_reg, o_mux_select, o_data_ready,
                                   o_cipher_valid, o_done}, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // T6
        run_enc(0, 0, 0, 1'b0, done_cyc, pulses, init_lsb, ready_cycles, freeze_err, first_mux);
        check("t6_done_cycle", done_cyc, 25);
        check("t6_cipher_pulses", pulses, 1);
        check("t6_init_lsb", init_lsb, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
